sio_host: RTL and testbench

//  Initiator end of the remote-IO serial link; the counterpart of the remote target.

---
 rtl/sio_host_pkg.sv | 43 ++++
 rtl/crc_16_4_usb.sv | 33 +++
 rtl/sio_host.sv | 171 +++++++++++++++++
 tb/tb_sio_host.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/sio_host_pkg.sv
// Shared constants, payload layouts and the nibble-wide CRC-16/USB step for the remote-IO link.
package sio_host_pkg;

   localparam int unsigned SLOT_W      = 6;
   localparam int unsigned FRAME_LEN   = 64;
   localparam int unsigned TX_DATA_NIB = 24;
   localparam int unsigned TX_CRC_NIB  = 4;
   localparam int unsigned RX_DATA_NIB = 12;
   localparam int unsigned RX_CRC_NIB  = 4;
   localparam logic [3:0]  IDLE_NIB    = 4'hF;

   // Target-side frame slots: pin takeover, last stream nibble, last rdata nibble, pin release
   localparam int unsigned TGT_DRV_SLOT   = 30;
   localparam int unsigned TGT_STREAM_END = 34;
   localparam int unsigned TGT_RDATA_END  = 42;
   localparam int unsigned TGT_RELEASE    = 47;

   localparam logic [15:0] CRC_INIT     = 16'hFFFF;
   localparam logic [15:0] CRC_XOROUT   = 16'hFFFF;
   localparam logic [15:0] CRC_POLY_REF = 16'hA001;

   typedef struct packed {
      logic [15:0] stream;
      logic [79:0] wdata;
   } tx_payload_t;

   typedef struct packed {
      logic [15:0] crc;
      logic [31:0] rdata;
      logic [15:0] stream;
   } rx_payload_t;

   // Reflected CRC-16 (poly 0x8005), one nibble per call, LSB of the nibble first
   function automatic logic [15:0] crc16_usb_nib(input logic [15:0] crc, input logic [3:0] nib);
      logic [15:0] v;
      v = crc;
      for (int i = 0; i < 4; i++) begin
         v = (v[0] ^ nib[i]) ? ((v >> 1) ^ CRC_POLY_REF) : (v >> 1);
      end
      return v;
   endfunction

endpackage

// File: rtl/crc_16_4_usb.sv
// CRC-16/USB accumulator taking one nibble per enabled cycle; outputs are already xor-finalised.
module crc_16_4_usb
   import sio_host_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_init,
   input  logic        i_ce,
   input  logic [3:0]  i_di,
   output logic [15:0] o_crc_c,
   output logic [15:0] o_nxt_c
);

   logic [15:0] r_crc;
   logic [15:0] w_nxt;

   assign w_nxt = crc16_usb_nib(r_crc, i_di);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_crc <= CRC_INIT;
      end else if (i_init) begin
         r_crc <= CRC_INIT;
      end else if (i_ce) begin
         r_crc <= w_nxt;
      end
   end

   // o_nxt_c lets the caller see the value that includes the nibble being accepted this cycle
   assign o_crc_c = r_crc ^ CRC_XOROUT;
   assign o_nxt_c = w_nxt ^ CRC_XOROUT;

endmodule

// File: rtl/sio_host.sv
// Initiator of the remote-IO serial link: fixed 64-slot frame, nibble TX of write data,
// stream word and CRC, then nibble RX of the target's stream word, read data and CRC.
module sio_host
   import sio_host_pkg::*;
#(
   parameter int unsigned RX_START = 34,
   parameter int unsigned LOCK_RUN = 8
) (
   input  logic        c,
   input  logic        rst_n,
   input  logic [79:0] wdata,
   input  logic [15:0] stream_in,
   output logic        frame,
   output logic [3:0]  td,
   output logic        tq,
   input  logic [3:0]  rd,
   output logic [31:0] rdata,
   output logic [15:0] stream_out,
   output logic        rvalid,
   output logic        link_ok,
   output logic [15:0] err_count
);

   localparam int unsigned RUN_W = $clog2(LOCK_RUN + 1);
   localparam int unsigned RX_NIB = RX_DATA_NIB + RX_CRC_NIB;

   localparam logic [SLOT_W-1:0] S_LAST       = SLOT_W'(FRAME_LEN - 1);
   localparam logic [SLOT_W-1:0] S_TX_DLAST   = SLOT_W'(TX_DATA_NIB - 1);
   localparam logic [SLOT_W-1:0] S_TX_CLAST   = SLOT_W'(TX_DATA_NIB + TX_CRC_NIB - 1);
   localparam logic [SLOT_W-1:0] S_RX_INIT    = SLOT_W'(RX_START + FRAME_LEN - 1);
   localparam logic [SLOT_W-1:0] S_RX_FIRST   = SLOT_W'(RX_START);
   localparam logic [SLOT_W-1:0] S_RX_CE_LAST = SLOT_W'(RX_START + RX_DATA_NIB - 1);
   localparam logic [SLOT_W-1:0] S_RX_LAST    = SLOT_W'(RX_START + RX_NIB - 1);
   localparam logic [SLOT_W-1:0] S_CHECK      = SLOT_W'(RX_START + RX_NIB);

   // The CRC check must land before the next frame's load slot
   if (RX_START + RX_NIB > FRAME_LEN - 2) begin : g_bad_rx_start
      $error("sio_host: RX_START too late, CRC check would cross into the next frame");
   end

   logic [SLOT_W-1:0] r_slot;
   logic              r_frame;
   logic [3:0]        r_td;
   logic              r_tq;
   logic [95:0]       r_tx_sr;
   logic [63:0]       r_rx_sr;
   logic [31:0]       r_rdata;
   logic [15:0]       r_stream_out;
   logic              r_rvalid;
   logic [RUN_W-1:0]  r_run;
   logic              r_link_ok;
   logic [15:0]       r_err_count;

   tx_payload_t       w_tx_load;
   rx_payload_t       w_rx;
   logic              w_tx_init;
   logic              w_tx_ce;
   logic              w_rx_init;
   logic              w_rx_ce;
   logic              w_rx_win;
   logic              w_pass;
   logic [15:0]       w_tx_crc;
   logic [15:0]       w_tx_crc_nxt;
   logic [15:0]       w_tx_crc_src;
   logic [1:0]        w_crc_sel;
   logic [15:0]       w_rx_crc;
   logic [15:0]       w_unused_rx_nxt;
   logic [RUN_W-1:0]  w_run_sat;

   assign w_tx_load = '{stream: stream_in, wdata: wdata};
   assign w_rx      = rx_payload_t'(r_rx_sr);

   assign w_tx_init = (r_slot == S_LAST);
   assign w_tx_ce   = (r_slot <= S_TX_DLAST);
   assign w_rx_init = (r_slot == S_RX_INIT);
   assign w_rx_ce   = (r_slot >= S_RX_FIRST) && (r_slot <= S_RX_CE_LAST);
   assign w_rx_win  = (r_slot >= S_RX_FIRST) && (r_slot <= S_RX_LAST);
   assign w_pass    = (w_rx_crc == w_rx.crc);

   // Slot 23 needs the CRC including the nibble accepted this cycle; later slots read the register
   assign w_crc_sel    = 2'(r_slot - S_TX_DLAST);
   assign w_tx_crc_src = (r_slot == S_TX_DLAST) ? w_tx_crc_nxt : w_tx_crc;

   assign w_run_sat = (r_run == RUN_W'(LOCK_RUN)) ? r_run : r_run + RUN_W'(1);

   crc_16_4_usb u_tx_crc (
      .clk     (c),
      .rst_n   (rst_n),
      .i_init  (w_tx_init),
      .i_ce    (w_tx_ce),
      .i_di    (r_tx_sr[3:0]),
      .o_crc_c (w_tx_crc),
      .o_nxt_c (w_tx_crc_nxt)
   );

   crc_16_4_usb u_rx_crc (
      .clk     (c),
      .rst_n   (rst_n),
      .i_init  (w_rx_init),
      .i_ce    (w_rx_ce),
      .i_di    (rd),
      .o_crc_c (w_rx_crc),
      .o_nxt_c (w_unused_rx_nxt)
   );

   always_ff @(posedge c or negedge rst_n) begin
      if (!rst_n) begin
         r_slot       <= S_LAST;
         r_frame      <= 1'b0;
         r_td         <= IDLE_NIB;
         r_tq         <= 1'b1;
         r_tx_sr      <= '0;
         r_rx_sr      <= '0;
         r_rdata      <= '0;
         r_stream_out <= '0;
         r_rvalid     <= 1'b0;
         r_run        <= '0;
         r_link_ok    <= 1'b0;
         r_err_count  <= '0;
      end else begin
         r_slot   <= r_slot + SLOT_W'(1);
         r_frame  <= (r_slot == S_LAST);
         r_rvalid <= 1'b0;

         // TX: td/tq are registered, so each branch prepares the value for the following slot
         if (r_slot == S_LAST) begin
            r_tx_sr <= w_tx_load;
            r_td    <= w_tx_load.wdata[3:0];
            r_tq    <= 1'b0;
         end else if (r_slot < S_TX_DLAST) begin
            r_tx_sr <= r_tx_sr >> 4;
            r_td    <= r_tx_sr[7:4];
         end else if (r_slot < S_TX_CLAST) begin
            r_td    <= w_tx_crc_src[{w_crc_sel, 2'b00} +: 4];
         end else begin
            r_td    <= IDLE_NIB;
            r_tq    <= 1'b1;
         end

         if (w_rx_win) begin
            r_rx_sr <= {rd, r_rx_sr[63:4]};
         end

         if (r_slot == S_CHECK) begin
            if (w_pass) begin
               r_rdata      <= w_rx.rdata;
               r_stream_out <= w_rx.stream;
               r_rvalid     <= 1'b1;
               r_run        <= w_run_sat;
               r_link_ok    <= (w_run_sat == RUN_W'(LOCK_RUN));
            end else begin
               r_run     <= '0;
               r_link_ok <= 1'b0;
               if (r_err_count != 16'hFFFF) begin
                  r_err_count <= r_err_count + 16'd1;
               end
            end
         end
      end
   end

   assign frame      = r_frame;
   assign td         = r_td;
   assign tq         = r_tq;
   assign rdata      = r_rdata;
   assign stream_out = r_stream_out;
   assign rvalid     = r_rvalid;
   assign link_ok    = r_link_ok;
   assign err_count  = r_err_count;

endmodule

// File: tb/tb_sio_host.sv
// Directed bench for sio_host: a slot-tracking target model drives rd, TX nibbles and RX
// results are checked against a bench-side CRC-16/USB model.
module tb_sio_host;
   import sio_host_pkg::*;

   localparam int RXS = 34;

   logic        c = 1'b0;
   logic        rst_n;
   logic [79:0] wdata;
   logic [15:0] stream_in;
   logic        frame;
   logic [3:0]  td;
   logic        tq;
   logic [3:0]  rd;
   logic [31:0] rdata;
   logic [15:0] stream_out;
   logic        rvalid;
   logic        link_ok;
   logic [15:0] err_count;

   sio_host #(.RX_START(RXS), .LOCK_RUN(8)) dut (
      .c          (c),
      .rst_n      (rst_n),
      .wdata      (wdata),
      .stream_in  (stream_in),
      .frame      (frame),
      .td         (td),
      .tq         (tq),
      .rd         (rd),
      .rdata      (rdata),
      .stream_out (stream_out),
      .rvalid     (rvalid),
      .link_ok    (link_ok),
      .err_count  (err_count)
   );

   always #5 c = ~c;

   typedef struct {
      int         slot;
      logic [3:0] td;
      logic       tq;
   } tx_vec_t;

   int          n_cmp = 0;
   int          n_bad = 0;
   logic [5:0]  tb_slot;
   int          tgt_mode;     // 0 good, 1 one bit flipped, 2 idle line
   logic [31:0] tgt_rdata;
   logic [15:0] tgt_stream;
   tx_vec_t     vec [16];

   function automatic logic [15:0] crc_nibs(input logic [95:0] data, input int n);
      logic [15:0] cr;
      logic        fb;
      cr = 16'hFFFF;
      for (int i = 0; i < n; i++) begin
         for (int b = 0; b < 4; b++) begin
            fb = cr[0] ^ data[4*i+b];
            cr = cr >> 1;
            if (fb) cr = cr ^ 16'hA001;
         end
      end
      return ~cr;
   endfunction

   // Target reply as seen at the host pin: 16 nibbles starting at host slot RXS
   function automatic logic [3:0] tgt_nib(input logic [5:0] slot);
      logic [63:0] word;
      logic [3:0]  n;
      int          k;
      if (tgt_mode == 2 || int'(slot) < RXS || int'(slot) > RXS + 15) return IDLE_NIB;
      k    = int'(slot) - RXS;
      word = {crc_nibs(96'({tgt_rdata, tgt_stream}), 12), tgt_rdata, tgt_stream};
      n    = word[4*k +: 4];
      if (tgt_mode == 1 && k == 5) n = n ^ 4'h2;
      return n;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, want %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge c);
      #1;
      tb_slot = tb_slot + 6'd1;
      rd      = tgt_nib(tb_slot);
   endtask

   // One full frame from the slot-63 load edge to the next slot 63
   task automatic run_frame(input int fno, input bit exp_pass, input logic [31:0] exp_rdata,
                            input logic [15:0] exp_sout, input bit exp_link,
                            input logic [15:0] exp_err, input bit tbl, input bit chg);
      logic [95:0] snap;
      logic [15:0] crc_tx;
      logic [3:0]  enib;
      snap   = {stream_in, wdata};
      crc_tx = crc_nibs(snap, 24);
      for (int s = 0; s < 64; s++) begin
         tick();
         if (chg && s == 5) wdata = ~wdata;
         if (s < 24)      enib = snap[4*s +: 4];
         else if (s < 28) enib = crc_tx[4*(s-24) +: 4];
         else             enib = 4'hF;
         chk($sformatf("f%0d td s%0d", fno, s), 32'(td), 32'(enib));
         chk($sformatf("f%0d tq s%0d", fno, s), 32'(tq), 32'(s >= 28));
         if (tbl) begin
            for (int v = 0; v < 16; v++) begin
               if (vec[v].slot == s) begin
                  chk($sformatf("vec%0d td", v), 32'(td), 32'(vec[v].td));
                  chk($sformatf("vec%0d tq", v), 32'(tq), 32'(vec[v].tq));
               end
            end
         end
         if (s == 0)  chk($sformatf("f%0d frame s0", fno), 32'(frame), 32'd1);
         if (s == 1)  chk($sformatf("f%0d frame s1", fno), 32'(frame), 32'd0);
         if (s == 50) chk($sformatf("f%0d rvalid s50", fno), 32'(rvalid), 32'd0);
         if (s == 51) chk($sformatf("f%0d rvalid s51", fno), 32'(rvalid), 32'(exp_pass));
         if (s == 52) chk($sformatf("f%0d rvalid s52", fno), 32'(rvalid), 32'd0);
         if (s == 60) begin
            chk($sformatf("f%0d rdata", fno), rdata, exp_rdata);
            chk($sformatf("f%0d stream_out", fno), 32'(stream_out), 32'(exp_sout));
            chk($sformatf("f%0d link_ok", fno), 32'(link_ok), 32'(exp_link));
            chk($sformatf("f%0d err_count", fno), 32'(err_count), 32'(exp_err));
         end
      end
   endtask

   initial begin
      logic [15:0] c1;
      rst_n      = 1'b0;
      rd         = 4'hF;
      tgt_mode   = 0;
      tgt_rdata  = 32'hDEADBEEF;
      tgt_stream = 16'hCAFE;
      wdata      = 80'h0123456789ABCDEF0011;
      stream_in  = 16'hBEEF;
      tb_slot    = 6'd63;

      c1 = crc_nibs({16'hBEEF, 80'h0123456789ABCDEF0011}, 24);
      vec[0]  = '{0, 4'h1, 1'b0};   vec[1]  = '{1, 4'h1, 1'b0};
      vec[2]  = '{2, 4'h0, 1'b0};   vec[3]  = '{3, 4'h0, 1'b0};
      vec[4]  = '{4, 4'hF, 1'b0};   vec[5]  = '{7, 4'hC, 1'b0};
      vec[6]  = '{20, 4'hF, 1'b0};  vec[7]  = '{21, 4'hE, 1'b0};
      vec[8]  = '{22, 4'hE, 1'b0};  vec[9]  = '{23, 4'hB, 1'b0};
      vec[10] = '{24, c1[3:0], 1'b0};   vec[11] = '{25, c1[7:4], 1'b0};
      vec[12] = '{26, c1[11:8], 1'b0};  vec[13] = '{27, c1[15:12], 1'b0};
      vec[14] = '{28, 4'hF, 1'b1};  vec[15] = '{63, 4'hF, 1'b1};

      repeat (3) @(posedge c);
      #1;
      chk("rst td", 32'(td), 32'hF);
      chk("rst tq", 32'(tq), 32'd1);
      chk("rst frame", 32'(frame), 32'd0);
      chk("rst rvalid", 32'(rvalid), 32'd0);
      chk("rst rdata", rdata, 32'd0);
      chk("rst stream_out", 32'(stream_out), 32'd0);
      chk("rst link_ok", 32'(link_ok), 32'd0);
      chk("rst err_count", 32'(err_count), 32'd0);
      rst_n = 1'b1;

      // Lock: 8 good frames, link_ok from frame 8
      for (int f = 1; f <= 9; f++) begin
         run_frame(f, 1'b1, 32'hDEADBEEF, 16'hCAFE, f >= 8, 16'd0, f == 1, 1'b0);
         wdata     = {$urandom, $urandom, 16'($urandom)};
         stream_in = 16'($urandom);
      end

      // Corrupted reply drops the link and holds the last good data
      tgt_mode = 1;
      run_frame(10, 1'b0, 32'hDEADBEEF, 16'hCAFE, 1'b0, 16'd1, 1'b0, 1'b0);
      tgt_mode   = 0;
      tgt_rdata  = 32'h13579BDF;
      tgt_stream = 16'h2468;
      for (int f = 11; f <= 18; f++) begin
         run_frame(f, 1'b1, 32'h13579BDF, 16'h2468, f >= 18, 16'd1, 1'b0, 1'b0);
         wdata = {$urandom, $urandom, 16'($urandom)};
      end

      // Idle line never passes; error counter saturates
      tgt_mode = 2;
      run_frame(19, 1'b0, 32'h13579BDF, 16'h2468, 1'b0, 16'd2, 1'b0, 1'b0);
      run_frame(20, 1'b0, 32'h13579BDF, 16'h2468, 1'b0, 16'd3, 1'b0, 1'b0);
      force dut.r_err_count = 16'hFFFE;
      #1;
      release dut.r_err_count;
      run_frame(21, 1'b0, 32'h13579BDF, 16'h2468, 1'b0, 16'hFFFF, 1'b0, 1'b0);
      run_frame(22, 1'b0, 32'h13579BDF, 16'h2468, 1'b0, 16'hFFFF, 1'b0, 1'b0);

      // wdata changes at slot 5; TX must keep the slot-63 snapshot
      tgt_mode   = 0;
      tgt_rdata  = 32'h0F1E2D3C;
      tgt_stream = 16'h5A5A;
      wdata      = 80'hA5A5_5A5A_F0F0_0F0F_3C3C;
      run_frame(23, 1'b1, 32'h0F1E2D3C, 16'h5A5A, 1'b0, 16'hFFFF, 1'b0, 1'b1);

      // Async reset at slot 12 of the next frame
      for (int s = 0; s <= 12; s++) tick();
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst tq", 32'(tq), 32'd1);
      chk("midrst td", 32'(td), 32'hF);
      chk("midrst rdata", rdata, 32'd0);
      chk("midrst err_count", 32'(err_count), 32'd0);
      repeat (3) @(posedge c);
      #2;
      chk("midrst hold tq", 32'(tq), 32'd1);
      chk("midrst hold frame", 32'(frame), 32'd0);
      rst_n   = 1'b1;
      tb_slot = 6'd63;
      rd      = tgt_nib(tb_slot);
      run_frame(25, 1'b1, 32'h0F1E2D3C, 16'h5A5A, 1'b0, 16'd0, 1'b0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
